uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl_if.sv | 29 ++
 rtl/uart_rx_ctrl.sv | 151 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive controller and its sampler/deserializer/host side.
// Build option UART_RX_PARITY_EN on the controller decides whether par_en/par_typ/pdata are used.
interface uart_rx_ctrl_if #(
  parameter int PRESCALE_W = 6
);
  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  par_typ;
  logic                  samp_out;
  logic [7:0]            pdata;
  logic                  samp_en;
  logic                  deser_en;
  logic                  edge_done;
  logic                  data_valid;
  logic                  par_err;
  logic                  stop_err;
  logic                  busy;

  modport master (
    output rx_in, prescale, par_en, par_typ, samp_out, pdata,
    input  samp_en, deser_en, edge_done, data_valid, par_err, stop_err, busy
  );

  modport slave (
    input  rx_in, prescale, par_en, par_typ, samp_out, pdata,
    output samp_en, deser_en, edge_done, data_valid, par_err, stop_err, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start/data/parity/stop sequencing, flags and data_valid pulse.
// UART_RX_PARITY_EN enables the PARITY state; without it parity is never checked and par_err is 0.
module uart_rx_ctrl #(
  parameter int PRESCALE_W = 6
) (
  input logic           clk,
  input logic           rst,
  uart_rx_ctrl_if.slave bus
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  stop_err_q, stop_err_d;
  logic                  data_valid_q, data_valid_d;
  logic [PRESCALE_W-1:0] presc_clamped;
  logic                  edge_done;
  logic                  par_err_cur;

  // Ratios below 4 leave too few clocks per bit for the sampler's majority vote.
  assign presc_clamped = (bus.prescale < PRESCALE_W'(4)) ? PRESCALE_W'(4) : bus.prescale;
  assign edge_done     = (state_q != IDLE) && (edge_cnt_q == presc_q - PRESCALE_W'(1));

`ifdef UART_RX_PARITY_EN
  logic par_en_q, par_en_d, par_typ_q, par_typ_d, par_err_q, par_err_d;
  assign par_err_cur = par_err_q;
`else
  logic unused_par;
  assign unused_par  = ^{bus.par_en, bus.par_typ, bus.pdata};
  assign par_err_cur = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    presc_d      = presc_q;
    bit_cnt_d    = bit_cnt_q;
    stop_err_d   = stop_err_q;
    data_valid_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_err_d    = par_err_q;
`endif
    if (state_q == IDLE) edge_cnt_d = '0;
    else                 edge_cnt_d = edge_done ? '0 : edge_cnt_q + PRESCALE_W'(1);

    case (state_q)
      IDLE: begin
        if (!bus.rx_in) begin
          state_d    = START;
          presc_d    = presc_clamped;
          bit_cnt_d  = '0;
          stop_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          par_en_d   = bus.par_en;
          par_typ_d  = bus.par_typ;
          par_err_d  = 1'b0;
`endif
        end
      end
      START: begin
        if (edge_done) begin
          // A start bit that reads high at its end was line noise.
          if (bus.samp_out) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
      end
      DATA: begin
        if (edge_done) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (edge_done) begin
          par_err_d = bus.samp_out ^ (^bus.pdata ^ par_typ_q);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (edge_done) begin
          stop_err_d   = ~bus.samp_out;
          data_valid_d = bus.samp_out & ~par_err_cur;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      edge_cnt_q   <= '0;
      presc_q      <= PRESCALE_W'(4);
      bit_cnt_q    <= '0;
      stop_err_q   <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      presc_q      <= presc_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_err_q   <= stop_err_d;
      data_valid_q <= data_valid_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_err_q <= par_err_d;
    end
  end
`endif

  assign bus.samp_en    = (state_q != IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.deser_en   = (state_q == DATA);
  assign bus.edge_done  = edge_done;
  assign bus.data_valid = data_valid_q;
  assign bus.par_err    = par_err_cur;
  assign bus.stop_err   = stop_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: table of whole frames plus glitch and mid-frame reset sequences.
// Sampler is modelled as a pass-through of rx_in; deserializer as an LSB-first shift register.
module tb_uart_rx_ctrl;
  localparam int PW = 6;
`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.PRESCALE_W(PW)) bus ();
  uart_rx_ctrl #(.PRESCALE_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] pdata_q;
  assign bus.samp_out = bus.rx_in;
  assign bus.pdata    = pdata_q;
  always @(posedge clk or negedge rst) begin
    if (!rst)                              pdata_q <= 8'h00;
    else if (bus.deser_en && bus.edge_done) pdata_q <= {bus.samp_out, pdata_q[7:1]};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         dv_total = 0;
  int         dv_last  = 0;
  int         deser_total = 0;
  always @(negedge clk) begin
    if (bus.data_valid) begin
      dv_total <= dv_total + 1;
      dv_last  <= cyc;
    end
    if (bus.deser_en) deser_total <= deser_total + 1;
  end

  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         presc;
    bit         pen;
    bit         ptyp;
    bit         pbit;
    bit         stopb;
    bit         scr;
    int         e_dvn;
    int         e_cyc;
    int         e_perr;
    int         e_serr;
  } vec_t;

  task automatic run_frame(input vec_t v, input int idx);
    int   t0, dv0, nper, p;
    logic seq [0:10];
    p    = (v.presc < 4) ? 4 : v.presc;
    nper = 0;
    seq[nper++] = 1'b0;
    for (int i = 0; i < 8; i++) seq[nper++] = v.data[i];
    if (HAS_PAR && v.pen) seq[nper++] = v.pbit;
    seq[nper++] = v.stopb;
    dv0 = dv_total;
    t0  = cyc;
    bus.prescale = PW'(v.presc);
    bus.par_en   = v.pen;
    bus.par_typ  = v.ptyp;
    bus.rx_in    = 1'b0;
    for (int k = 0; k < nper; k++) begin
      for (int c = 0; c < p; c++) begin
        step(1);
        bus.rx_in = seq[k];
        if (v.scr && k == 0 && c == 0) begin
          bus.prescale = PW'(7);
          bus.par_en   = ~v.pen;
          bus.par_typ  = ~v.ptyp;
        end
      end
    end
    step(1);
    bus.rx_in = 1'b1;
    step(4);
    chk($sformatf("row%0d dv_count", idx), dv_total - dv0, v.e_dvn);
    chk($sformatf("row%0d dv_cycle", idx), (dv_total > dv0) ? dv_last - t0 : -1, v.e_cyc);
    chk($sformatf("row%0d pdata", idx), int'(bus.pdata), int'(v.data));
    chk($sformatf("row%0d par_err", idx), int'(bus.par_err), v.e_perr);
    chk($sformatf("row%0d stop_err", idx), int'(bus.stop_err), v.e_serr);
    chk($sformatf("row%0d busy_after", idx), int'(bus.busy), 0);
  endtask

  vec_t tbl [6];
  vec_t good;

  initial begin
    // data, presc, pen, ptyp, pbit, stop, scramble, dv_count, dv_cycle, par_err, stop_err
`ifdef UART_RX_PARITY_EN
    tbl[0] = '{8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 89, 0, 0};
    tbl[1] = '{8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, -1, 1, 0};
    tbl[4] = '{8'h96, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 56, 0, 0};
`else
    tbl[0] = '{8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 81, 0, 0};
    tbl[1] = '{8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 81, 0, 0};
    tbl[4] = '{8'h96, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 51, 0, 0};
`endif
    tbl[2] = '{8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 0, 1};
    tbl[3] = '{8'h5A, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 41, 0, 0};
    tbl[5] = '{8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 81, 0, 0};
    good   = '{8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 81, 0, 0};

    bus.rx_in    = 1'b1;
    bus.prescale = PW'(8);
    bus.par_en   = 1'b0;
    bus.par_typ  = 1'b0;
    rst          = 1'b0;
    step(3);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset samp_en", int'(bus.samp_en), 0);
    chk("reset edge_done", int'(bus.edge_done), 0);
    chk("reset data_valid", int'(bus.data_valid), 0);
    rst = 1'b1;
    step(2);

    for (int i = 0; i < 6; i++) run_frame(tbl[i], i);

    // Glitch: line low for two clocks, start bit re-reads high at end of its period
    begin
      int t0, dv0, ds0;
      run_frame(tbl[2], 90);
      dv0 = dv_total;
      ds0 = deser_total;
      t0  = cyc;
      bus.prescale = PW'(8);
      bus.rx_in = 1'b0;
      step(2);
      bus.rx_in = 1'b1;
      step(1);
      chk("glitch busy_in_start", int'(bus.busy), 1);
      step(5);
      chk("glitch edge_done_at_8", int'(bus.edge_done), 1);
      chk("glitch cycle", cyc - t0, 8);
      step(1);
      chk("glitch idle_after_start", int'(bus.busy), 0);
      step(4);
      chk("glitch deser_en_seen", deser_total - ds0, 0);
      chk("glitch data_valid", dv_total - dv0, 0);
      chk("glitch stop_err", int'(bus.stop_err), 0);
      chk("glitch par_err", int'(bus.par_err), 0);
    end

    // Reset asserted in the middle of data bit 3
    bus.prescale = PW'(8);
    bus.par_en   = 1'b0;
    bus.rx_in    = 1'b0;
    step(36);
    chk("midrst deser_en_before", int'(bus.deser_en), 1);
    rst = 1'b0;
    #1;
    chk("midrst busy", int'(bus.busy), 0);
    chk("midrst samp_en", int'(bus.samp_en), 0);
    chk("midrst deser_en", int'(bus.deser_en), 0);
    chk("midrst edge_done", int'(bus.edge_done), 0);
    chk("midrst data_valid", int'(bus.data_valid), 0);
    chk("midrst par_err", int'(bus.par_err), 0);
    chk("midrst stop_err", int'(bus.stop_err), 0);
    bus.rx_in = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    run_frame(good, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
